// File: rtl/fft_frame_loader.sv
// Streams one N-point complex frame into the FFT load port, starts it, awaits done.
// Optional watchdog on the done wait: define FFT_LOADER_TIMEOUT_EN.
module fft_frame_loader #(
  parameter int N_POINTS       = 32,
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 16,
  parameter int START_GAP      = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_valid,
  output logic              sample_ready,
  input  logic [DATA_W-1:0] sample_real,
  input  logic [DATA_W-1:0] sample_imag,
  input  logic              abort,
  output logic [ADDR_W-1:0] LoadDataAddr,
  output logic [DATA_W-1:0] data_real_out,
  output logic [DATA_W-1:0] data_imag_out,
  output logic              LoadDataWrite,
  output logic              start_FFT,
  input  logic              FFT_done,
  output logic              frame_done,
  output logic [15:0]       frame_count,
  output logic              busy,
  output logic              timeout_flag
);

  typedef enum logic [1:0] {FILL, GAP, START, WAIT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [3:0]        gap_q, gap_d;
  logic              done_prev_q;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] re_q, re_d;
  logic [DATA_W-1:0] im_q, im_d;
  logic              start_q, start_d;
  logic              fdone_q, fdone_d;
  logic [15:0]       fcount_q, fcount_d;
  logic              busy_q, busy_d;
  logic              hs;
  logic              cmpl;

`ifdef FFT_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wcnt_q, wcnt_d;
  logic          tflag_q, tflag_d;
`endif

  assign sample_ready = (state_q == FILL) && !abort && !reset;
  assign hs           = sample_valid && sample_ready;
  // Only a rising done edge seen inside WAIT counts as completion
  assign cmpl         = (state_q == WAIT) && FFT_done && !done_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    gap_d    = gap_q;
    wr_d     = 1'b0;
    addr_d   = addr_q;
    re_d     = re_q;
    im_d     = im_q;
    start_d  = 1'b0;
    fdone_d  = 1'b0;
    fcount_d = fcount_q;
`ifdef FFT_LOADER_TIMEOUT_EN
    wcnt_d   = wcnt_q;
    tflag_d  = tflag_q;
`endif
    unique case (state_q)
      FILL: begin
        if (hs) begin
          wr_d   = 1'b1;
          addr_d = cnt_q;
          re_d   = sample_real;
          im_d   = sample_imag;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == ADDR_W'(N_POINTS - 1)) begin
            cnt_d   = '0;
            gap_d   = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        gap_d = gap_q + 4'd1;
        if (gap_q == 4'(START_GAP - 1)) state_d = START;
      end
      START: begin
        start_d = 1'b1;
        state_d = WAIT;
`ifdef FFT_LOADER_TIMEOUT_EN
        wcnt_d  = '0;
`endif
      end
      WAIT: begin
        if (cmpl) begin
          fdone_d  = 1'b1;
          fcount_d = fcount_q + 16'd1;
          state_d  = FILL;
        end
`ifdef FFT_LOADER_TIMEOUT_EN
        else if (wcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          tflag_d = 1'b1;
          state_d = FILL;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
`endif
      end
      default: state_d = FILL;
    endcase
    if (abort) begin
      state_d  = FILL;
      cnt_d    = '0;
      start_d  = 1'b0;
      fdone_d  = 1'b0;
      fcount_d = fcount_q;
`ifdef FFT_LOADER_TIMEOUT_EN
      tflag_d  = tflag_q;
`endif
    end
    busy_d = (state_d != FILL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      gap_q       <= '0;
      done_prev_q <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      re_q        <= '0;
      im_q        <= '0;
      start_q     <= 1'b0;
      fdone_q     <= 1'b0;
      fcount_q    <= '0;
      busy_q      <= 1'b0;
`ifdef FFT_LOADER_TIMEOUT_EN
      wcnt_q      <= '0;
      tflag_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      done_prev_q <= FFT_done;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      re_q        <= re_d;
      im_q        <= im_d;
      start_q     <= start_d;
      fdone_q     <= fdone_d;
      fcount_q    <= fcount_d;
      busy_q      <= busy_d;
`ifdef FFT_LOADER_TIMEOUT_EN
      wcnt_q      <= wcnt_d;
      tflag_q     <= tflag_d;
`endif
    end
  end

  assign LoadDataWrite = wr_q;
  assign LoadDataAddr  = addr_q;
  assign data_real_out = re_q;
  assign data_imag_out = im_q;
  assign start_FFT     = start_q;
  assign frame_done    = fdone_q;
  assign frame_count   = fcount_q;
  assign busy          = busy_q;
`ifdef FFT_LOADER_TIMEOUT_EN
  assign timeout_flag  = tflag_q;
`else
  assign timeout_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed phases with random samples,
// checked every cycle against a timeline model of the load/start/done protocol.
module tb_fft_frame_loader;
  localparam int N   = 32;
  localparam int AW  = 5;
  localparam int DW  = 16;
  localparam int GAP = 2;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sv = 1'b0;
  logic          ab = 1'b0;
  logic          dn = 1'b0;
  logic [DW-1:0] sr = '0;
  logic [DW-1:0] si = '0;
  logic          sample_ready;
  logic [AW-1:0] addr;
  logic [DW-1:0] dre, dim;
  logic          wr, start, fdone, busy, tflag;
  logic [15:0]   fcount;

  always #5 clk = ~clk;

  fft_frame_loader #(
    .N_POINTS(N), .ADDR_W(AW), .DATA_W(DW),
    .START_GAP(GAP), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clk), .reset(rst),
    .sample_valid(sv), .sample_ready(sample_ready),
    .sample_real(sr), .sample_imag(si),
    .abort(ab),
    .LoadDataAddr(addr),
    .data_real_out(dre), .data_imag_out(dim),
    .LoadDataWrite(wr), .start_FFT(start),
    .FFT_done(dn), .frame_done(fdone),
    .frame_count(fcount), .busy(busy),
    .timeout_flag(tflag)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Timeline model: cycle index, frame fill progress, cycle at which start is seen
  longint        cyc = 0;
  longint        start_at = -1;
  bit            m_fill = 1'b0;
  int            m_cnt = 0;
  bit            m_prev = 1'b0;
  logic [15:0]   m_frames = '0;
  bit            m_tflag = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_re = '0;
  logic [DW-1:0] e_im = '0;
  bit            dlev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input bit a, input bit d,
                      input logic [DW-1:0] r, input logic [DW-1:0] im);
    bit hs, cmpl, tmo, e_wr, e_start;
    sv = v; ab = a; dn = d; sr = r; si = im;
    #1;
    chk("ready", sample_ready, m_fill && !a);
    hs   = v && m_fill && !a;
    cmpl = !m_fill && start_at >= 0 && cyc >= start_at
           && d && !m_prev && !a;
    tmo  = 1'b0;
`ifdef FFT_LOADER_TIMEOUT_EN
    tmo  = !m_fill && start_at >= 0 && cyc == start_at + TO - 1
           && !cmpl && !a;
`endif
    e_wr    = hs;
    e_start = !m_fill && (cyc + 1 == start_at) && !a;
    if (hs) begin
      e_addr = AW'(m_cnt);
      e_re   = r;
      e_im   = im;
      m_cnt++;
      if (m_cnt == N) begin
        m_cnt    = 0;
        m_fill   = 1'b0;
        start_at = cyc + 2 + GAP;
      end
    end
    if (cmpl) begin
      m_frames = m_frames + 16'd1;
      m_fill   = 1'b1;
      start_at = -1;
    end
    if (tmo) begin
      m_tflag  = 1'b1;
      m_fill   = 1'b1;
      start_at = -1;
    end
    if (a) begin
      m_fill   = 1'b1;
      m_cnt    = 0;
      start_at = -1;
    end
    m_prev = d;
    @(posedge clk);
    #1;
    cyc++;
    chk("write", wr, e_wr);
    chk("addr", addr, e_addr);
    chk("data_re", dre, e_re);
    chk("data_im", dim, e_im);
    chk("start", start, e_start);
    chk("frame_done", fdone, cmpl);
    chk("frame_count", fcount, m_frames);
    chk("busy", busy, !m_fill);
    chk("timeout", tflag, m_tflag);
  endtask

  task automatic do_reset();
    rst = 1'b1; sv = 1'b0; ab = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc += 2;
    chk("rst_ready", sample_ready, 1'b0);
    chk("rst_outs", {wr, start, fdone, busy, tflag}, 5'b0);
    chk("rst_addr", addr, 0);
    chk("rst_data", {dre, dim}, 0);
    chk("rst_count", fcount, 0);
    rst = 1'b0;
    m_fill = 1'b1; m_cnt = 0; start_at = -1; m_prev = 1'b0;
    m_frames = '0; m_tflag = 1'b0;
    e_addr = '0; e_re = '0; e_im = '0;
  endtask

  task automatic send_frame(input int every);
    for (int i = 0; i < N * every; i++)
      tick(i % every == 0, 1'b0, dlev, DW'($urandom), DW'($urandom));
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, d, '0, '0);
  endtask

  initial begin
    // 1: ramp frame, back to back
    do_reset();
    for (int i = 0; i < N; i++) tick(1'b1, 1'b0, 1'b0, DW'(i), DW'(-i));
    idle(5, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    // 2+3: sparse valid, done already high at WAIT entry
    dlev = 1'b1;
    send_frame(3);
    idle(6, 1'b1);
    idle(5, 1'b0);
    idle(3, 1'b1);
    idle(1, 1'b0);
    // 4: abort on the 17th handshake, then in START, then in WAIT
    dlev = 1'b0;
    for (int i = 0; i < 16; i++)
      tick(1'b1, 1'b0, 1'b0, DW'($urandom), DW'($urandom));
    tick(1'b1, 1'b1, 1'b0, DW'($urandom), DW'($urandom));
    send_frame(1);
    idle(2, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    idle(3, 1'b0);
    send_frame(2);
    idle(5, 1'b0);
    tick(1'b0, 1'b1, 1'b0, '0, '0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    // 5: reach three frames, reset during WAIT
    send_frame(1);
    idle(6, 1'b0);
    idle(2, 1'b1);
    idle(1, 1'b0);
    send_frame(1);
    idle(6, 1'b0);
    do_reset();
    idle(2, 1'b1);
    idle(2, 1'b0);
    // 6: long done-less wait, then another frame to completion
    send_frame(1);
    idle(TO + 10, 1'b0);
    send_frame(1);
    idle(6, 1'b0);
    idle(2, 1'b1);
    idle(2, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
